hdmi_text_render: RTL
=====================

Name: hdmi_text_render

Overview:
Text-mode pixel pipeline between the video timing generator and the TMDS encoder, all in the pixel clock domain. Maps each 640x480 active pixel to an 80x30 cell of 8x16 pixels. Fetches character and attribute bytes from the dual-port char/attr RAM read ports, applying the AVR-written row offset for hardware scrolling. Looks up the glyph row, applies the 16-colour palette and blink, and outputs 24-bit RGB with sync/DE delayed to match.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows per screen
ADDR_W, 13, RAM address width
LATENCY, 4, input-to-output pipeline depth in clk_pixel cycles (fixed; must not be changed)

Ports:
clk_pixel  in  1  pixel clock; the only clock
rstn  in  1  reset, synchronous, active-low
cx  in  10  current pixel x (0..639 active)
cy  in  10  current pixel y (0..479 active)
de_in  in  1  display enable
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
row_offset  in  8  scroll offset in character rows (quasi-static, core-domain register)
ram_address  out  13  shared char/attr RAM read address
ram_char_re  out  1  char RAM read enable
ram_attr_re  out  1  attr RAM read enable
ram_char_data  in  8  char RAM q; valid 1 cycle after re; held while re low
ram_attr_data  in  8  attr RAM q; same timing
cursor_col  in  7  cursor column (used only with the optional feature)
cursor_row  in  5  cursor row (used only with the optional feature)
rgb  out  24  {R,G,B} pixel
de_out, hsync_out, vsync_out  out  1 each  inputs delayed by LATENCY

Behaviour:
- Reset (rstn low at clk_pixel edge): rgb, ram_address, re outputs, de/hsync/vsync outputs, all pipeline registers and frame_cnt go to 0.
- Valid pixel: de_in=1 and cx<640 and cy<480. Otherwise re stays low and the pixel's rgb is 0.
- S0 (registered): col=cx[9:3]; row=cy[8:4]. off = row_offset if row_offset<ROWS, else 0. r=row+off; if r>=ROWS then r-=ROWS. ram_address = r*80+col, computed as (r<<6)+(r<<4)+col. ram_char_re=ram_attr_re=1 only for a valid pixel with cx[2:0]==0; one read per cell.
- S1: RAM returns data. S2: latch char/attr when the delayed re is 1. Issue font ROM read at {char, cy[3:0]} (delayed), with 1-cycle latency.
- S3: bit = glyph[7-cx_d[2:0]].
  - attr[3:0] = fg index; attr[6:4] = bg index (0..7); attr[7] = blink.
  - If attr[7]=1 and frame_cnt[5]=1, force fg=bg.
  - rgb = palette[bit?fg:bg]; rgb = 0 if the delayed pixel is not valid.
- Total latency is exactly 4 cycles for rgb, de_out, hsync_out and vsync_out.
- frame_cnt: 6-bit counter, increments on the registered rising edge of vsync_in, wraps 63->0.
- row_offset changing mid-frame takes effect from the next cell fetch; no tearing protection.

Optional Feature:
HDMI_TEXT_CURSOR_EN
- Defined: a cursor is drawn at the pixel where the delayed col==cursor_col, row(unscrolled)==cursor_row, cy[3:0] in {14,15}, and frame_cnt[4]=1. Its colour is palette[fg], regardless of glyph bit. Cursor ports outside range (col>=80 or row>=30) draw nothing.
- Undefined: cursor ports are ignored and no cursor logic is synthesised.

Decomposition:
- Package hdmi_text_pkg:
  - COLS, ROWS, CELL_W=8, CELL_H=16, LATENCY
  - attr field positions
  - 16x24-bit CGA palette constant: 0=000000, 1=0000AA, 2=00AA00, ... 7=AAAAAA, 8=555555, ... 15=FFFFFF
- Sub-module hdmi_font_rom: 4096x8 synchronous ROM addressed {char[7:0], line[3:0]}, initialised from a font file.

Test Plan:
- Reset held 3 cycles during active video -> rgb=0, re=0, de_out=0; after release the first valid output appears 4 cycles after the first de_in.
- cx=8, cy=16, row_offset=0 -> ram_address=81, re pulse for 1 cycle; cx=9..15 -> no re.
- row_offset=5, cy=28*16 -> r=3, ram_address=240+col. row_offset=45 -> treated as 0.
- Char 0x41 with font line 0x18, attr 0x1E, cx 0..7 -> rgb = 0000AA,0000AA,0000AA,FFFF55,FFFF55,0000AA,0000AA,0000AA.
- attr 0x9F with 32 vsync rising edges -> foreground shows bg colour; after 64 edges it restores.
- With HDMI_TEXT_CURSOR_EN, cursor (2,1), cy=30, frame_cnt=16 -> cell pixels = palette[fg]; at cy=29 -> normal glyph.

Source files
------------

// File: rtl/hdmi_text_pkg.sv
// hdmi_text_pkg: shared constants, pixel pipeline record, CGA palette and font content
// for the text renderer.
package hdmi_text_pkg;
   localparam int COLS    = 80;
   localparam int ROWS    = 30;
   localparam int CELL_W  = 8;
   localparam int CELL_H  = 16;
   localparam int LATENCY = 4;

   localparam int ATTR_FG_LSB = 0;
   localparam int ATTR_BG_LSB = 4;
   localparam int ATTR_BLINK  = 7;

   localparam logic [23:0] PALETTE [16] = '{
      24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
      24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
      24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
      24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
   };

   typedef struct packed {
      logic                        valid;
      logic                        de;
      logic                        hs;
      logic                        vs;
      logic [$clog2(CELL_W)-1:0]   px;
      logic [$clog2(CELL_H)-1:0]   line;
      logic [6:0]                  col;
      logic [4:0]                  row;
   } pix_t;

   // Built-in font: a drawn 'A' glyph, every other code a deterministic line pattern.
   function automatic logic [7:0] font_line(input logic [7:0] c, input logic [3:0] l);
      logic [7:0] a;
      a = (l == 4'd2) ? 8'h18 :
          (l == 4'd3) ? 8'h3C :
          (l == 4'd6) ? 8'h7E :
          (l >= 4'd4 && l <= 4'd10) ? 8'h66 : 8'h00;
      return (c == 8'h41) ? a : c ^ {l, l};
   endfunction
endpackage

// File: rtl/hdmi_font_rom.sv
// hdmi_font_rom: 4096x8 synchronous glyph ROM, one-cycle read latency.
//   clk_i  : pixel clock
//   rstn_i : synchronous active-low reset, clears the output register
//   addr_i : {char[7:0], line[3:0]}
//   data_o : glyph row, MSB is the leftmost pixel
module hdmi_font_rom
   import hdmi_text_pkg::*;
(
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [11:0] addr_i,
   output logic [7:0]  data_o
);
   logic [7:0] data_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) data_q <= '0;
      else         data_q <= font_line(addr_i[11:4], addr_i[3:0]);
   end

   assign data_o = data_q;
endmodule

// File: rtl/hdmi_text_render.sv
// hdmi_text_render: 80x30 text-mode pixel pipeline, 4-cycle latency from pixel
// coordinates to RGB with sync/DE delayed to match.
//   clk_pixel, rstn                 : pixel clock, synchronous active-low reset
//   cx, cy, de_in, hsync_in, vsync_in : timing generator inputs
//   row_offset                      : hardware scroll in character rows
//   ram_address, ram_char_re, ram_attr_re, ram_char_data, ram_attr_data : char/attr RAM read port
//   cursor_col, cursor_row          : cursor cell (only with HDMI_TEXT_CURSOR_EN defined)
//   rgb, de_out, hsync_out, vsync_out : pixel output
// Optional feature macro: HDMI_TEXT_CURSOR_EN enables the blinking underline cursor.
module hdmi_text_render
   import hdmi_text_pkg::*;
#(
   parameter int ADDR_W = 13
) (
   input  logic              clk_pixel,
   input  logic              rstn,
   input  logic [9:0]        cx,
   input  logic [9:0]        cy,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [7:0]        row_offset,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_char_re,
   output logic              ram_attr_re,
   input  logic [7:0]        ram_char_data,
   input  logic [7:0]        ram_attr_data,
   input  logic [6:0]        cursor_col,
   input  logic [4:0]        cursor_row,
   output logic [23:0]       rgb,
   output logic              de_out,
   output logic              hsync_out,
   output logic              vsync_out
);
   pix_t              p_d;
   pix_t              p_q [LATENCY-1];
   logic [4:0]        off;
   logic [5:0]        r_sum;
   logic [ADDR_W-1:0] r_w;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              re_d, re_q, re1_q;
   logic [7:0]        char_q, attr_q;
   logic [7:0]        glyph;
   logic              vs_q, vs_prev_q;
   logic [5:0]        frame_cnt_q;
   logic [3:0]        fg, bg, idx;
   logic [23:0]       rgb_d, rgb_q;
   logic              de_q, hs_q, vs_out_q;

   always_comb begin
      p_d       = '0;
      p_d.valid = de_in && cx < 10'(COLS * CELL_W) && cy < 10'(ROWS * CELL_H);
      p_d.de    = de_in;
      p_d.hs    = hsync_in;
      p_d.vs    = vsync_in;
      p_d.px    = cx[2:0];
      p_d.line  = cy[3:0];
      p_d.col   = cx[9:3];
      p_d.row   = cy[8:4];
      off       = (row_offset < 8'(ROWS)) ? row_offset[4:0] : 5'd0;
      r_sum     = {1'b0, p_d.row} + {1'b0, off};
      r_w       = ADDR_W'((r_sum >= 6'(ROWS)) ? r_sum - 6'(ROWS) : r_sum);
      addr_d    = (r_w << 6) + (r_w << 4) + ADDR_W'(p_d.col);
      re_d      = p_d.valid && cx[2:0] == 3'd0;
   end

   // First pixel of a cell takes char straight from the RAM port; the rest reuse the latch.
   hdmi_font_rom u_font (
      .clk_i  (clk_pixel),
      .rstn_i (rstn),
      .addr_i ({re1_q ? ram_char_data : char_q, p_q[1].line}),
      .data_o (glyph)
   );

   always_comb begin
      fg    = attr_q[ATTR_FG_LSB +: 4];
      bg    = {1'b0, attr_q[ATTR_BG_LSB +: 3]};
      fg    = (attr_q[ATTR_BLINK] && frame_cnt_q[5]) ? bg : fg;
      idx   = glyph[~p_q[2].px] ? fg : bg;
`ifdef HDMI_TEXT_CURSOR_EN
      idx   = (p_q[2].col == cursor_col && p_q[2].row == cursor_row &&
               p_q[2].line[3:1] == 3'b111 && frame_cnt_q[4] &&
               cursor_col < 7'(COLS) && cursor_row < 5'(ROWS)) ? fg : idx;
`endif
      rgb_d = p_q[2].valid ? PALETTE[idx] : 24'h0;
   end

`ifndef HDMI_TEXT_CURSOR_EN
   logic unused_cursor;
   assign unused_cursor = ^{cursor_col, cursor_row, p_q[2].col, p_q[2].row};
`endif

   always_ff @(posedge clk_pixel) begin
      if (!rstn) begin
         p_q         <= '{default: '0};
         addr_q      <= '0;
         re_q        <= 1'b0;
         re1_q       <= 1'b0;
         char_q      <= '0;
         attr_q      <= '0;
         vs_q        <= 1'b0;
         vs_prev_q   <= 1'b0;
         frame_cnt_q <= '0;
         rgb_q       <= '0;
         de_q        <= 1'b0;
         hs_q        <= 1'b0;
         vs_out_q    <= 1'b0;
      end else begin
         p_q[0]      <= p_d;
         p_q[1]      <= p_q[0];
         p_q[2]      <= p_q[1];
         addr_q      <= addr_d;
         re_q        <= re_d;
         re1_q       <= re_q;
         char_q      <= re1_q ? ram_char_data : char_q;
         attr_q      <= re1_q ? ram_attr_data : attr_q;
         vs_q        <= vsync_in;
         vs_prev_q   <= vs_q;
         frame_cnt_q <= (vs_q && !vs_prev_q) ? frame_cnt_q + 6'd1 : frame_cnt_q;
         rgb_q       <= rgb_d;
         de_q        <= p_q[2].de;
         hs_q        <= p_q[2].hs;
         vs_out_q    <= p_q[2].vs;
      end
   end

   assign ram_address = addr_q;
   assign ram_char_re = re_q;
   assign ram_attr_re = re_q;
   assign rgb         = rgb_q;
   assign de_out      = de_q;
   assign hsync_out   = hs_q;
   assign vsync_out   = vs_out_q;
endmodule
